// File: rtl/fpnew_classify_pipe.sv
// fpnew_classify_pipe
//   Decodes one IEEE-style operand of a fixed FP format into a RISC-V fclass
//   one-hot mask plus NaN/sNaN/Inf/zero flags. The decode happens at the input.
//   The result then travels through NumPipeRegs elastic register stages. Every
//   stage has its own valid/ready handshake, so backpressure stalls the stage
//   without dropping or duplicating operands.
//
// Parameters
//   FpFormat    0=FP32 1=FP64 2=FP16 3=FP8(5/2) 4=BF16
//   NumPipeRegs register stages, 0..4 (0 = purely combinational)
//   TagWidth    width of the opaque tag carried with each operand
//
// Ports
//   clk_i, rst_ni            clock, async active-low reset
//   flush_i                  kills all in-flight operands at the next edge
//   in_valid_i/in_ready_o    input handshake; operand_i={sign,exp,man}, tag_i
//   out_valid_o/out_ready_i  output handshake
//   class_o                  fclass one-hot mask
//   is_nan_o, is_snan_o, is_inf_o, is_zero_o  flags derived from class_o
//   tag_o                    tag of the result currently presented
module fpnew_classify_pipe #(
  parameter logic [2:0]  FpFormat    = 3'd0,
  parameter int unsigned NumPipeRegs = 1,
  parameter int unsigned TagWidth    = 4,
  localparam int unsigned EXP_BITS = (FpFormat == 3'd1) ? 11 :
                                     (FpFormat == 3'd2 || FpFormat == 3'd3) ? 5 : 8,
  localparam int unsigned MAN_BITS = (FpFormat == 3'd1) ? 52 :
                                     (FpFormat == 3'd2) ? 10 :
                                     (FpFormat == 3'd3) ? 2  :
                                     (FpFormat == 3'd4) ? 7  : 23,
  localparam int unsigned WIDTH    = 1 + EXP_BITS + MAN_BITS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WIDTH-1:0]    operand_i,
  input  logic [TagWidth-1:0] tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [9:0]          class_o,
  output logic                is_nan_o,
  output logic                is_snan_o,
  output logic                is_inf_o,
  output logic                is_zero_o,
  output logic [TagWidth-1:0] tag_o
);

  logic                sign;
  logic [EXP_BITS-1:0] exp_f;
  logic [MAN_BITS-1:0] man_f;
  logic [9:0]          dec_cls;

  assign {sign, exp_f, man_f} = operand_i;

  // The pipe registers carry the 10-bit mask, not the raw operand.
  always_comb begin
    dec_cls = '0;
    if (&exp_f) begin
      if (man_f == '0)             dec_cls[sign ? 0 : 7] = 1'b1;
      else if (man_f[MAN_BITS-1])  dec_cls[9] = 1'b1;   // quiet NaN, sign ignored
      else                         dec_cls[8] = 1'b1;   // signalling NaN
    end else if (exp_f == '0) begin
      if (man_f == '0)             dec_cls[sign ? 3 : 4] = 1'b1;
      else                         dec_cls[sign ? 2 : 5] = 1'b1;
    end else begin
      dec_cls[sign ? 1 : 6] = 1'b1;
    end
  end

  if (NumPipeRegs > 0) begin : g_pipe
    localparam int N = NumPipeRegs;

    logic [N-1:0]                vld_pipe;
    logic [N-1:0][9:0]           cls_pipe;
    logic [N-1:0][TagWidth-1:0]  tag_pipe;
    logic [N:0]                  rdy;
    logic [N-1:0]                up_vld;
    logic [N-1:0][9:0]           up_cls;
    logic [N-1:0][TagWidth-1:0]  up_tag;

    // A stage can take new data when it is empty or its content moves on
    // this cycle. This lets a full pipe accept and emit in the same cycle.
    always_comb begin
      rdy    = '0;
      rdy[N] = out_ready_i;
      for (int i = N - 1; i >= 0; i--) rdy[i] = ~vld_pipe[i] | rdy[i+1];
    end

    always_comb begin
      up_vld    = '0;
      up_cls    = '0;
      up_tag    = '0;
      up_vld[0] = in_valid_i;
      up_cls[0] = dec_cls;
      up_tag[0] = tag_i;
      for (int i = 1; i < N; i++) begin
        up_vld[i] = vld_pipe[i-1];
        up_cls[i] = cls_pipe[i-1];
        up_tag[i] = tag_pipe[i-1];
      end
    end

    // Flush clears only the valid bits. Data loads only with a valid upstream,
    // so held data stays put while a stage is stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_pipe <= '0;
        cls_pipe <= '0;
        tag_pipe <= '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (flush_i) begin
            vld_pipe[i] <= 1'b0;
          end else if (rdy[i]) begin
            vld_pipe[i] <= up_vld[i];
            if (up_vld[i]) begin
              cls_pipe[i] <= up_cls[i];
              tag_pipe[i] <= up_tag[i];
            end
          end
        end
      end
    end

    assign in_ready_o  = rdy[0] & ~flush_i;
    assign out_valid_o = vld_pipe[N-1];
    assign class_o     = cls_pipe[N-1];
    assign tag_o       = tag_pipe[N-1];
  end else begin : g_comb
    assign in_ready_o  = out_ready_i;
    assign out_valid_o = in_valid_i;
    assign class_o     = dec_cls;
    assign tag_o       = tag_i;
  end

  assign is_nan_o  = class_o[9] | class_o[8];
  assign is_snan_o = class_o[8];
  assign is_inf_o  = class_o[7] | class_o[0];
  assign is_zero_o = class_o[4] | class_o[3];

endmodule
